hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Stall/flush controller for the 5-stage pipeline. Keeps a shadow scoreboard of the
//   destination register and Tnew held by the E and M stages and compares it with the
//   D-stage Tuse. Also owns a multi-cycle mult/div busy counter.
//   Drives the enable of PC and IF/ID, and the flush of the ID/EX pipeline register.
// PARAMETERS
//   MULT_CYCLES  5   E-stage busy cycles for mult/multu
//   DIV_CYCLES   10  E-stage busy cycles for div/divu
//   CNT_W        4   busy counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//   clk         in   1      clock, rising edge
//   reset       in   1      asynchronous, active-low reset (0 = reset)
//   rsD         in   5      rs field of instruction in D
//   rtD         in   5      rt field of instruction in D
//   tuse_rsD    in   2      cycles until D needs rs; 3 = rs not read
//   tuse_rtD    in   2      cycles until D needs rt; 3 = rt not read
//   a3D         in   5      destination register of D instruction; 0 = none
//   tnewD       in   2      Tnew of D instruction on entering E (ALU/mfhi=1, load=2, none=0)
//   md_startD   in   1      D is mult/multu/div/divu
//   md_divD     in   1      with md_startD: 1 = div/divu, 0 = mult/multu
//   md_useD     in   1      D is mfhi/mflo/mthi/mtlo
//   en_pc       out  1      PC write enable
//   en_ifid     out  1      IF/ID enable
//   flush_idex  out  1      ID/EX flush (inserts bubble)
//   md_busy     out  1      mult/div unit busy
//   md_cnt      out  CNT_W  remaining busy cycles
// BEHAVIOUR
//   State: a3E,tnewE,a3M,tnewM (5/2/5/2 bits), cnt (CNT_W). All cleared to 0 asynchronously
//     while reset=0; clearing is immediate, including mid mult/div.
//   Hazard (combinational, per source s in {rs,rt}):
//     hz_s = (sD!=0) & (tuse_sD!=3) &
//            ((sD==a3E & tnewE>tuse_sD) | (sD==a3M & tnewM>tuse_sD)).
//     Register 0 never stalls.
//   md_stall = (md_startD | md_useD) & (cnt!=0).
//   stall = hz_rs | hz_rt | md_stall.
//   Outputs: en_pc = en_ifid = ~stall; flush_idex = stall; md_busy = (cnt!=0); md_cnt = cnt.
//   Shadow update at posedge clk (reset=1):
//     E <= stall ? {0,0} : {a3D,tnewD}     (a bubble carries no destination)
//     M <= {a3E, (tnewE==0) ? 0 : tnewE-1} (saturating decrement)
//   Counter at posedge clk:
//     if md_startD & ~stall -> cnt <= md_divD ? DIV_CYCLES : MULT_CYCLES
//     else if cnt!=0        -> cnt <= cnt-1
//     else hold 0.
//   A start issued while busy is stalled and does not reload.
//   Load and decrement never coincide: a load happens only when cnt==0.
//   The counter decrements independently of the hazard stall.
//   Outputs during/after reset: en_pc=1, en_ifid=1, flush_idex=0, md_busy=0, md_cnt=0.
//   Reason: zeroed state cannot match a nonzero source register and cnt is 0.
//   Zero-latency control: a stall asserts in the same cycle as the offending D instruction.
//   One cycle after the stall condition clears, D issues normally.
// TESTING
//   1. Release reset, D = add $3,$1,$2 (tnewD=1) -> en_pc=1, flush_idex=0; next cycle a3E=3, tnewE=1.
//   2. lw $5 (tnewD=2), then D = add using rs=$5 with tuse=1 -> stall for exactly 1 cycle
//      (tnewE=2>1). Next cycle tnewM=1, not >1 -> issue.
//   3. lw $5, then beq on $5 (tuse=0) -> stall 2 cycles (E:2>0, then M:1>0); issues on the
//      3rd cycle.
//   4. Dest $0 with tnewD=2, then a reader of $0 with tuse=0 -> no stall.
//   5. div issued (DIV_CYCLES=10), then mflo in D -> md_cnt counts 10..1, flush_idex=1 for
//      10 cycles, mflo issues when md_cnt=0. With MULT_CYCLES=5, mult then mfhi stalls 5.
//   6. Drive reset=0 asynchronously mid-div (md_cnt=6) -> md_cnt=0, md_busy=0, en_pc=1
//      before the next clock edge.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: E/M destination+Tnew scoreboard against D-stage Tuse,
// plus the multi-cycle mult/div busy counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [1:0]       tuse_rsD,
  input  logic [1:0]       tuse_rtD,
  input  logic [4:0]       a3D,
  input  logic [1:0]       tnewD,
  input  logic             md_startD,
  input  logic             md_divD,
  input  logic             md_useD,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             flush_idex,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [4:0]       a3e_reg, a3m_reg, a3e_next, a3m_next;
  logic [1:0]       tnewe_reg, tnewm_reg, tnewe_next, tnewm_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [4:0] src [2];
  logic [1:0] tuse [2];
  logic [1:0] hz;
  logic       md_stall;
  logic       stall;

  assign src[0]  = rsD;
  assign src[1]  = rtD;
  assign tuse[0] = tuse_rsD;
  assign tuse[1] = tuse_rtD;

  // Tuse of 3 means the operand is never read; $0 is hard-wired and never waits.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hz[gi] = (src[gi] != 5'd0) && (tuse[gi] != 2'd3) &&
                      (((src[gi] == a3e_reg) && (tnewe_reg > tuse[gi])) ||
                       ((src[gi] == a3m_reg) && (tnewm_reg > tuse[gi])));
    end
  endgenerate

  assign md_stall = (md_startD || md_useD) && (cnt_reg != '0);
  assign stall    = (|hz) || md_stall;

  assign en_pc      = ~stall;
  assign en_ifid    = ~stall;
  assign flush_idex = stall;
  assign md_busy    = (cnt_reg != '0);
  assign md_cnt     = cnt_reg;

  always_comb begin
    a3e_next   = stall ? 5'd0 : a3D;
    tnewe_next = stall ? 2'd0 : tnewD;
    a3m_next   = a3e_reg;
    tnewm_next = (tnewe_reg == 2'd0) ? 2'd0 : tnewe_reg - 2'd1;
    cnt_next   = cnt_reg;
    // A start can only pass when the counter is idle, so load never meets decrement.
    if (md_startD && !stall)
      cnt_next = md_divD ? DIV_LOAD : MULT_LOAD;
    else if (cnt_reg != '0)
      cnt_next = cnt_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3e_reg   <= 5'd0;
      tnewe_reg <= 2'd0;
      a3m_reg   <= 5'd0;
      tnewm_reg <= 2'd0;
      cnt_reg   <= '0;
    end else begin
      a3e_reg   <= a3e_next;
      tnewe_reg <= tnewe_next;
      a3m_reg   <= a3m_next;
      tnewm_reg <= tnewm_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: data hazards, $0, mult/div busy, async reset.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, a3D;
  logic [1:0] tuse_rsD, tuse_rtD, tnewD;
  logic       md_startD, md_divD, md_useD;
  logic       en_pc, en_ifid, flush_idex, md_busy;
  logic [3:0] md_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_stall_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rsD       (rsD),
    .rtD       (rtD),
    .tuse_rsD  (tuse_rsD),
    .tuse_rtD  (tuse_rtD),
    .a3D       (a3D),
    .tnewD     (tnewD),
    .md_startD (md_startD),
    .md_divD   (md_divD),
    .md_useD   (md_useD),
    .en_pc     (en_pc),
    .en_ifid   (en_ifid),
    .flush_idex(flush_idex),
    .md_busy   (md_busy),
    .md_cnt    (md_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stall view: flush asserted and both enables dropped, or the opposite.
  task automatic check_stall(input string tag, input logic exp_stall);
    check({tag, "_flush"}, 32'(flush_idex), 32'(exp_stall));
    check({tag, "_en_pc"}, 32'(en_pc), 32'(!exp_stall));
    check({tag, "_en_ifid"}, 32'(en_ifid), 32'(!exp_stall));
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic st, input logic dv, input logic us);
    rsD = rs; tuse_rsD = trs; rtD = rt; tuse_rtD = trt;
    a3D = a3; tnewD = tn; md_startD = st; md_divD = dv; md_useD = us;
    #1;
    $display("t=%0t D rs=%0d/%0d rt=%0d/%0d a3=%0d tnew=%0d md=%0d%0d%0d -> stall=%0d cnt=%0d",
             $time, rs, trs, rt, trt, a3, tn, st, dv, us, flush_idex, md_cnt);
  endtask

  task automatic nop();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_d(5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    check_stall("rst", 1'b0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_cnt", 32'(md_cnt), 32'd0);
    #10 reset = 1'b1;

    // 1: add $3,$1,$2 issues; a dependent beq on $3 (tuse 0) then sees tnewE=1.
    tick();
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    check_stall("add_issue", 1'b0);
    tick();
    set_d(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_stall("add_dep_e", 1'b1);
    tick();
    check_stall("add_dep_m", 1'b0);

    // 2: lw $5 then ALU reader of $5 with tuse 1 -> one-cycle stall.
    tick(); nop(); tick(); nop(); tick();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    check_stall("lw_issue", 1'b0);
    tick();
    set_d(5'd5, 2'd1, 5'd0, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
    check_stall("lw_alu_c1", 1'b1);
    tick();
    check_stall("lw_alu_c2", 1'b0);

    // 3: lw $5 then beq on $5 via rt (tuse 0) -> two-cycle stall.
    tick(); nop(); tick(); nop(); tick();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_stall("lw_beq_c1", 1'b1);
    tick();
    check_stall("lw_beq_c2", 1'b1);
    tick();
    check_stall("lw_beq_c3", 1'b0);

    // 4: writes to $0 never stall; an unread operand (tuse 3) never stalls.
    tick(); nop(); tick(); nop(); tick();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_stall("reg0", 1'b0);
    tick();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd7, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_stall("tuse3", 1'b0);

    // 5a: div then mflo -> ten stalled cycles counting 10..1.
    tick(); nop(); tick(); nop(); tick();
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    check_stall("div_issue", 1'b0);
    check("div_idle_busy", 32'(md_busy), 32'd0);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int k = 10; k >= 1; k--) begin
      check("div_cnt", 32'(md_cnt), 32'(k));
      check("div_stall", 32'(flush_idex), 32'd1);
      check("div_busy", 32'(md_busy), 32'd1);
      tick();
    end
    check("div_done_cnt", 32'(md_cnt), 32'd0);
    check_stall("mflo_issue", 1'b0);

    // 5b: mult then mfhi -> five stalled cycles.
    tick();
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int k = 5; k >= 1; k--) begin
      check("mult_cnt", 32'(md_cnt), 32'(k));
      check("mult_stall", 32'(flush_idex), 32'd1);
      tick();
    end
    check_stall("mfhi_issue", 1'b0);

    // 5c: a div arriving while mult is busy stalls and does not reload.
    tick();
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_d(5'd3, 2'd1, 5'd4, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 5; k >= 1; k--) begin
      check("busy_start_cnt", 32'(md_cnt), 32'(k));
      check("busy_start_stall", 32'(flush_idex), 32'd1);
      tick();
    end
    check_stall("div2_issue", 1'b0);
    tick();
    check("div2_load", 32'(md_cnt), 32'd10);

    // 6: asynchronous reset mid-div clears the counter before any clock edge.
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick(); tick();
    check("pre_rst_cnt", 32'(md_cnt), 32'd6);
    #1 reset = 1'b0;
    #1;
    check("arst_cnt", 32'(md_cnt), 32'd0);
    check("arst_busy", 32'(md_busy), 32'd0);
    check_stall("arst", 1'b0);
    tick();
    check("arst_hold_cnt", 32'(md_cnt), 32'd0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
